// File: rtl/bus_pkg.sv
// Shared types and helpers for the serial bus arbiter.
// rr_pick scans from the pointer upward and wraps, returning the first requester found.
package bus_pkg;

  localparam int MAX_MASTERS = 8;
  localparam int IDX_W       = 3;

  typedef enum logic [1:0] {IDLE, GRANT, RESUME} arb_state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  function automatic rr_pick_t rr_pick(input logic [MAX_MASTERS-1:0] req,
                                       input logic [IDX_W-1:0]       ptr,
                                       input int                     n);
    rr_pick_t         r;
    logic [IDX_W-1:0] j;
    r = '0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      j = IDX_W'((int'(ptr) + i) % n);
      if (i < n && !r.found && req[j]) begin
        r.found = 1'b1;
        r.idx   = j;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the bus masters and the central arbiter.
// master: requester/slave-split side; slave: the arbiter itself.
interface bus_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int SEL_WIDTH   = 1
);
  logic [NUM_MASTERS-1:0] mreq;
  logic                   split;
  logic [NUM_MASTERS-1:0] mgrant;
  logic [SEL_WIDTH-1:0]   msel;
  logic                   bus_busy;
  logic [NUM_MASTERS-1:0] preempt;
  logic                   split_pending;

  modport master (output mreq, split,
                  input  mgrant, msel, bus_busy, preempt, split_pending);
  modport slave  (input  mreq, split,
                  output mgrant, msel, bus_busy, preempt, split_pending);
endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin selector: first request at or after ptr, wrapping.
module rr_priority_picker import bus_pkg::*; #(
  parameter int NUM_MASTERS = 2,
  parameter int SEL_WIDTH   = 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [SEL_WIDTH-1:0]   ptr,
  output logic [SEL_WIDTH-1:0]   idx,
  output logic                   found
);
  rr_pick_t pick;

  always_comb begin
    pick  = rr_pick(MAX_MASTERS'(req), IDX_W'(ptr), NUM_MASTERS);
    idx   = SEL_WIDTH'(pick.idx);
    found = pick.found;
  end
endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the serial bus with one tracked split transaction
// and an optional watchdog that revokes grants held too long.
module bus_arbiter import bus_pkg::*; #(
  parameter int NUM_MASTERS = 2,
  parameter int MAX_HOLD    = 0,
  parameter int SEL_WIDTH   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input logic           clk,
  input logic           rstn,
  bus_arbiter_if.slave  bus
);
  localparam int                     HOLD_W   = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLD_W:0]        HOLD_LIM = (HOLD_W+1)'(MAX_HOLD);
  localparam logic [HOLD_W:0]        HOLD_ONE = (HOLD_W+1)'(1);
  localparam logic [NUM_MASTERS-1:0] ONE      = NUM_MASTERS'(1);
  localparam logic [SEL_WIDTH-1:0]   SEL_ONE  = SEL_WIDTH'(1);
  localparam logic [SEL_WIDTH-1:0]   LAST     = SEL_WIDTH'(NUM_MASTERS - 1);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d, preempt_q, preempt_d, eligible;
  logic [SEL_WIDTH-1:0]   msel_q, msel_d, owner_q, owner_d, rr_q, rr_d, sown_q, sown_d;
  logic [SEL_WIDTH-1:0]   pick_idx, owner_inc;
  logic                   pend_q, pend_d, split_q;
  logic                   split_rise, split_fall, pick_found, wd_expire, owner_req, sown_req;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [HOLD_W:0]        hold_inc;

  // The parked split owner keeps mreq high but must not win normal arbitration.
  assign eligible   = bus.mreq & ~(pend_q ? (ONE << sown_q) : '0);
  assign split_rise = bus.split & ~split_q;
  assign split_fall = ~bus.split & split_q & pend_q;
  assign owner_req  = bus.mreq[owner_q];
  assign sown_req   = bus.mreq[sown_q];
  assign owner_inc  = (owner_q == LAST) ? '0 : owner_q + SEL_ONE;
  assign hold_inc   = {1'b0, hold_q} + HOLD_ONE;
  assign wd_expire  = (MAX_HOLD > 0) && (hold_inc == HOLD_LIM);

  rr_priority_picker #(.NUM_MASTERS(NUM_MASTERS), .SEL_WIDTH(SEL_WIDTH)) u_pick (
    .req   (eligible),
    .ptr   (rr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    msel_d    = msel_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    sown_d    = sown_q;
    pend_d    = pend_q;
    hold_d    = hold_q;
    preempt_d = '0;
    if (split_fall) pend_d = 1'b0;
    // Slave is already in SEND: resume wins over everything else this cycle.
    if (split_fall && sown_req) begin
      if (state_q == GRANT && owner_q != sown_q) preempt_d = ONE << owner_q;
      state_d = RESUME;
      grant_d = ONE << sown_q;
      msel_d  = sown_q;
      owner_d = sown_q;
      hold_d  = '0;
    end else begin
      case (state_q)
        IDLE: if (pick_found) begin
          state_d = GRANT;
          grant_d = ONE << pick_idx;
          msel_d  = pick_idx;
          owner_d = pick_idx;
          hold_d  = '0;
        end
        RESUME: if (!owner_req) begin
          state_d = IDLE;
          grant_d = '0;
          rr_d    = owner_inc;
        end else begin
          state_d = GRANT;
          hold_d  = '0;
        end
        GRANT: if (!owner_req) begin
          state_d = IDLE;
          grant_d = '0;
          rr_d    = owner_inc;
        end else if (split_rise && !pend_q) begin
          state_d = IDLE;
          grant_d = '0;
          sown_d  = owner_q;
          pend_d  = 1'b1;
          rr_d    = owner_inc;
        end else if (wd_expire) begin
          state_d   = IDLE;
          grant_d   = '0;
          preempt_d = ONE << owner_q;
          rr_d      = owner_inc;
        end else begin
          hold_d = hold_inc[HOLD_W-1:0];
        end
        default: begin
          state_d = IDLE;
          grant_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      msel_q    <= '0;
      owner_q   <= '0;
      rr_q      <= '0;
      sown_q    <= '0;
      pend_q    <= 1'b0;
      hold_q    <= '0;
      preempt_q <= '0;
      split_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      msel_q    <= msel_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      sown_q    <= sown_d;
      pend_q    <= pend_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
      split_q   <= bus.split;
    end
  end

  assign bus.mgrant        = grant_q;
  assign bus.msel          = msel_q;
  assign bus.bus_busy      = |grant_q;
  assign bus.preempt       = preempt_q;
  assign bus.split_pending = pend_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench: dut_a has no watchdog, dut_b uses MAX_HOLD=4.
module tb_bus_arbiter;
  logic clk = 1'b0;
  logic rstn;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bus_arbiter_if #(.NUM_MASTERS(2), .SEL_WIDTH(1)) ifa ();
  bus_arbiter_if #(.NUM_MASTERS(2), .SEL_WIDTH(1)) ifb ();

  bus_arbiter #(.NUM_MASTERS(2), .MAX_HOLD(0)) dut_a (.clk(clk), .rstn(rstn), .bus(ifa));
  bus_arbiter #(.NUM_MASTERS(2), .MAX_HOLD(4)) dut_b (.clk(clk), .rstn(rstn), .bus(ifb));

  typedef struct {
    string      tag;
    int         cyc;
    bit         dut;
    logic [7:0] g;
    logic [7:0] p;
    logic       pd;
    logic [2:0] ms;
    bit         cm;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic exp_at(input string tag, input int at, input bit d, input logic [7:0] g,
                        input logic [7:0] p, input logic pd, input logic [2:0] ms, input bit cm);
    exp_t e;
    e.tag = tag; e.cyc = at; e.dut = d; e.g = g; e.p = p; e.pd = pd; e.ms = ms; e.cm = cm;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : mon
    exp_t        e;
    logic [31:0] g, p, pd, ms, bb;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e  = sb.pop_front();
      g  = e.dut ? 32'(ifb.mgrant)        : 32'(ifa.mgrant);
      p  = e.dut ? 32'(ifb.preempt)       : 32'(ifa.preempt);
      pd = e.dut ? 32'(ifb.split_pending) : 32'(ifa.split_pending);
      ms = e.dut ? 32'(ifb.msel)          : 32'(ifa.msel);
      bb = e.dut ? 32'(ifb.bus_busy)      : 32'(ifa.bus_busy);
      if (e.cyc != cyc) chk({e.tag, "_late"}, 32'(cyc), 32'(e.cyc));
      chk({e.tag, "_mgrant"}, g, 32'(e.g));
      chk({e.tag, "_busy"}, bb, 32'(|e.g));
      chk({e.tag, "_preempt"}, p, 32'(e.p));
      chk({e.tag, "_pend"}, pd, 32'(e.pd));
      if (e.cm) chk({e.tag, "_msel"}, ms, 32'(e.ms));
    end
  end

  initial begin
    #50000;
    $display("FAIL timeout: got cycle %0d expected finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    int w;
    logic [7:0] g;
    rstn = 1'b1;
    ifa.mreq = '0; ifa.split = 1'b0;
    ifb.mreq = '0; ifb.split = 1'b0;
    #1 rstn = 1'b0;
    #1;
    chk("rst_a_mgrant", 32'(ifa.mgrant), 0);
    chk("rst_a_msel", 32'(ifa.msel), 0);
    chk("rst_a_busy", 32'(ifa.bus_busy), 0);
    chk("rst_a_preempt", 32'(ifa.preempt), 0);
    chk("rst_a_pend", 32'(ifa.split_pending), 0);
    chk("rst_b_mgrant", 32'(ifb.mgrant), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    tick(1);

    // basic grant and release, 1-cycle latency
    s = cyc; ifa.mreq = 2'b01;
    exp_at("basic_g", s+1, 0, 8'h01, 0, 0, 0, 1);
    exp_at("basic_hold", s+5, 0, 8'h01, 0, 0, 0, 1);
    exp_at("basic_rel", s+6, 0, 8'h00, 0, 0, 0, 1);
    tick(5); ifa.mreq = 2'b00;
    tick(2);

    // alternation on dut_b: 3 grant cycles then one idle turnaround
    s = cyc; ifb.mreq = 2'b11;
    for (int k = 0; k < 4; k++) begin
      w = k % 2;
      g = (w == 1) ? 8'h02 : 8'h01;
      for (int j = 1; j <= 3; j++) exp_at("alt_grant", s+4*k+j, 1, g, 0, 0, 3'(w), 1);
      exp_at("alt_gap", s+4*k+4, 1, 8'h00, 0, 0, 3'(w), 1);
    end
    for (int k = 0; k < 4; k++) begin
      w = k % 2;
      tick(3);
      if (k == 3) ifb.mreq = '0; else ifb.mreq[w] = 1'b0;
      tick(1);
      if (k < 3) ifb.mreq[w] = 1'b1;
    end
    tick(1);

    // watchdog revokes master1 after 4 cycles, master0 wins after turnaround
    s = cyc; ifb.mreq = 2'b10;
    exp_at("wd_g1", s+1, 1, 8'h02, 0, 0, 1, 1);
    exp_at("wd_hold", s+4, 1, 8'h02, 0, 0, 1, 1);
    exp_at("wd_revoke", s+5, 1, 8'h00, 8'h02, 0, 1, 1);
    exp_at("wd_next", s+6, 1, 8'h01, 8'h00, 0, 0, 1);
    exp_at("wd_done", s+7, 1, 8'h00, 8'h00, 0, 0, 1);
    tick(2); ifb.mreq = 2'b11;
    tick(4); ifb.mreq = 2'b00;
    tick(2);

    // release coinciding with watchdog expiry is a plain release
    s = cyc; ifb.mreq = 2'b01;
    exp_at("wdrel_g", s+1, 1, 8'h01, 0, 0, 0, 1);
    exp_at("wdrel_hold", s+4, 1, 8'h01, 0, 0, 0, 1);
    exp_at("wdrel_rel", s+5, 1, 8'h00, 8'h00, 0, 0, 1);
    tick(4); ifb.mreq = 2'b00;
    tick(2);

    // split park, other master served, resume preempts it
    s = cyc; ifa.mreq = 2'b01;
    exp_at("sp_g0", s+1, 0, 8'h01, 0, 0, 0, 1);
    exp_at("sp_park", s+2, 0, 8'h00, 0, 1, 0, 1);
    exp_at("sp_g1", s+3, 0, 8'h02, 0, 1, 1, 1);
    exp_at("sp_g1b", s+4, 0, 8'h02, 0, 1, 1, 1);
    exp_at("sp_resume", s+5, 0, 8'h01, 8'h02, 0, 0, 1);
    exp_at("sp_own", s+6, 0, 8'h01, 8'h00, 0, 0, 1);
    exp_at("sp_rel", s+7, 0, 8'h00, 0, 0, 0, 1);
    exp_at("sp_retry", s+8, 0, 8'h02, 0, 0, 1, 1);
    exp_at("sp_end", s+9, 0, 8'h00, 0, 0, 1, 1);
    tick(1); ifa.split = 1'b1;
    tick(1); ifa.mreq = 2'b11;
    tick(2); ifa.split = 1'b0;
    tick(2); ifa.mreq = 2'b10;
    tick(2); ifa.mreq = 2'b00;
    tick(2);

    // resume with split owner no longer requesting
    s = cyc; ifa.mreq = 2'b01;
    exp_at("spx_g0", s+1, 0, 8'h01, 0, 0, 0, 1);
    exp_at("spx_park", s+2, 0, 8'h00, 0, 1, 0, 1);
    exp_at("spx_wait", s+3, 0, 8'h00, 0, 1, 0, 1);
    exp_at("spx_clear", s+4, 0, 8'h00, 0, 0, 0, 1);
    exp_at("spx_idle", s+5, 0, 8'h00, 0, 0, 0, 1);
    tick(1); ifa.split = 1'b1;
    tick(1); ifa.mreq = 2'b00;
    tick(1); ifa.split = 1'b0;
    tick(3);

    // async reset mid-grant, pointer returns to 0
    s = cyc; ifa.mreq = 2'b01;
    exp_at("rr_g0", s+1, 0, 8'h01, 0, 0, 0, 1);
    exp_at("rr_rel", s+2, 0, 8'h00, 0, 0, 0, 1);
    exp_at("rr_g1", s+3, 0, 8'h02, 0, 0, 1, 1);
    tick(1); ifa.mreq = 2'b00;
    tick(1); ifa.mreq = 2'b10;
    tick(1);
    #4;
    rstn = 1'b0; ifa.mreq = 2'b00;
    #1;
    chk("arst_mgrant", 32'(ifa.mgrant), 0);
    chk("arst_busy", 32'(ifa.bus_busy), 0);
    chk("arst_msel", 32'(ifa.msel), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    tick(1);
    s = cyc; ifa.mreq = 2'b11;
    exp_at("post_rst_g0", s+1, 0, 8'h01, 0, 0, 0, 1);
    exp_at("post_rst_hold", s+2, 0, 8'h01, 0, 0, 0, 1);
    tick(2); ifa.mreq = 2'b00;
    tick(3);

    for (int i = 0; i < 10 && sb.size() != 0; i++) tick(1);
    chk("sb_drain", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Central arbiter for the serial system bus.
- Shares the single wr_bus/rd_bus serial path among NUM_MASTERS master ports using round-robin priority.
- Tracks one outstanding split transaction and re-grants the bus to the split owner when the slave leaves SPLIT to SEND; preempts the current owner if needed.
- Drives the master-select index used by the bus muxes. An optional watchdog revokes grants held too long.

Parameters:
- NUM_MASTERS, 2, number of requesting master ports (2..8).
- MAX_HOLD, 0, max consecutive cycles one grant may be held; 0 disables the watchdog.
- SEL_WIDTH, $clog2(NUM_MASTERS) (min 1), width of the select index.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- mreq  in  NUM_MASTERS  per-master bus request; held high for the whole transaction, including split wait.
- split  in  1  OR of the slaves' split outputs; high while the addressed slave is in SPLIT.
- mgrant  out  NUM_MASTERS  one-hot grant, registered.
- msel  out  SEL_WIDTH  index of the granted master (mux select); holds its last value when no grant.
- bus_busy  out  1  high whenever any mgrant bit is high.
- preempt  out  NUM_MASTERS  one-cycle pulse to a master whose grant was revoked by split resume or watchdog; that master must retry.
- split_pending  out  1  high while a split owner is recorded.

Behaviour:
Reset (async assert, sync release):
- mgrant=0, msel=0, bus_busy=0, preempt=0, split_pending=0.
- rr pointer=0, hold counter=0, state=IDLE.

States: IDLE, GRANT, RESUME.

IDLE:
- Eligible requests = mreq with the split owner's bit masked while split_pending.
- Any eligible request moves to GRANT; winner = first eligible index at or after rr pointer, wrapping.
- Grant is visible on mgrant/msel the cycle after the request is sampled: 1-cycle grant latency.

GRANT:
- Owner mreq low -> IDLE.
  - mgrant cleared next cycle; 1 idle turnaround cycle before any new grant.
  - rr pointer = owner+1 mod NUM_MASTERS.
- split rising edge while in GRANT and no split pending:
  - record owner id, set split_pending, clear the grant, go IDLE.
  - No preempt pulse; the owner keeps mreq high.
  - rr pointer advances past the owner.
- split rising edge while split_pending already set is a protocol error: ignored; the second master keeps its grant.
- Watchdog (MAX_HOLD>0): hold counter increments each GRANT cycle and resets on entry. On reaching MAX_HOLD, the grant is revoked, preempt[owner] pulses, rr pointer advances, and the state goes IDLE.

RESUME entry:
- Trigger: split falling edge while split_pending, from any state.
- If the state is GRANT, the current owner loses its grant that edge, with a preempt pulse (unless the owner is the split owner).
- RESUME drives mgrant[split owner] and msel=split owner and clears split_pending, then goes to GRANT with the split owner. The normal release and watchdog rules apply; the hold counter restarts.
- Resume grant is visible the cycle after split is seen low: no turnaround cycle, because the slave is already in SEND.
- If the split owner's mreq is low at resume, split_pending is cleared and no grant is issued.

Simultaneous events:
- Split falling edge takes priority over release, watchdog and new arbitration in the same cycle.
- Owner release in the same cycle as watchdog expiry -> treated as release, no preempt.

Invariants:
- mgrant is always one-hot or zero.
- preempt is never asserted for more than 1 cycle.
- The split owner never receives a normal grant while split_pending.

Reset mid-transaction: all grants drop immediately (async), and split state is lost.

Decomposition:
- Shared package bus_pkg holds:
  - arbiter state enum {IDLE, GRANT, RESUME};
  - the MAX_MASTERS=8 constant;
  - a function rr_pick(req, ptr) returning the index and a found flag.
- One natural sub-module: rr_priority_picker, the combinational round-robin selector (mask by pointer, find first, wrap). It is instantiated once.
- Split edge detection and the watchdog stay in the top module.

Test Plan:
- NUM_MASTERS=2, mreq=2'b01 at cycle 0 -> mgrant=01, msel=0 at cycle 1. Drop mreq at cycle 5 -> mgrant=00 at cycle 6, bus_busy=0.
- Both masters request continuously, each dropping mreq 3 cycles after grant -> grants alternate 0,1,0,1 with exactly 1 idle cycle between each.
- Master0 granted, split rises -> mgrant=00 and split_pending=1 next cycle. Master1 then granted. Split falls -> next cycle mgrant=01, msel=0, preempt[1] pulses 1 cycle, split_pending=0.
- MAX_HOLD=4, master1 holds mreq -> grant revoked after 4 GRANT cycles with preempt[1] pulse. Master0 requesting gets the grant after the turnaround cycle.
- Split falls while split owner's mreq=0 -> split_pending clears, no grant, no preempt.
- Assert rstn=0 asynchronously mid-grant -> mgrant=0 without a clock edge. After release, first request is granted from rr pointer 0.
